// File: rtl/trainled2_chain_ctrl.sv
// rtl/trainled2_chain_ctrl.sv - TrainLED2 daisy-chain frame sequencer with pulse-width bit encoding
module trainled2_chain_ctrl #(
    parameter int NODES        = 4,
    parameter int NODE_W       = 2,
    parameter int BIT_PERIOD   = 24,
    parameter int T0H          = 6,
    parameter int T1H          = 16,
    parameter int LATCH_CYCLES = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_node,
    input  logic [1:0]        wr_chan,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic              auto_en,
    output logic              busy,
    output logic              frame_done,
    output logic              dout
);

    localparam int FRAME_BITS = NODES * 24;
    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [PW-1:0]     PH_LAST   = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0]     T0_LAST   = PW'(T0H - 1);
    localparam logic [PW-1:0]     T1_LAST   = PW'(T1H - 1);
    localparam logic [LW-1:0]     LAT_LAST  = LW'(LATCH_CYCLES - 1);
    localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t state, state_next;

    // Frame bit n (transmission order) lives at index n of both buffers.
    // The active buffer is shifted right after each bit so bit 0 is always
    // the one on the wire.
    logic [FRAME_BITS-1:0] wr_buf;
    logic [FRAME_BITS-1:0] act_buf;

    logic [PW-1:0]     phase;
    logic [4:0]        cbit;
    logic [NODE_W-1:0] node;
    logic [LW-1:0]     latch_cnt;

    logic high_done;
    logic bit_done;
    logic last_bit;
    logic latch_done;

    // Terminal-count decodes for the current state's counter
    always_comb begin
        high_done  = (phase == (act_buf[0] ? T1_LAST : T0_LAST));
        bit_done   = (phase == PH_LAST);
        last_bit   = (node == NODE_LAST) && (cbit == 5'd23);
        latch_done = (latch_cnt == LAT_LAST);
    end

    // Host write port: one byte per node/channel, MSB placed first in frame order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_buf <= '0;
        end else if (wr_en) begin
            for (int n = 0; n < NODES; n++) begin
                for (int c = 0; c < 3; c++) begin
                    if (wr_node == NODE_W'(n) && wr_chan == 2'(c)) begin
                        for (int b = 0; b < 8; b++) begin
                            wr_buf[n*24 + c*8 + 7 - b] <= wr_data[b];
                        end
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start || auto_en) state_next = S_LOAD;
            S_LOAD:  state_next = S_HIGH;
            S_HIGH:  if (high_done) state_next = S_LOW;
            S_LOW:   if (bit_done) state_next = last_bit ? S_LATCH : S_HIGH;
            S_LATCH: if (latch_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Snapshot, bit shifting and the phase/bit/node/latch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_buf   <= '0;
            phase     <= '0;
            cbit      <= '0;
            node      <= '0;
            latch_cnt <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    act_buf   <= wr_buf;
                    phase     <= '0;
                    cbit      <= '0;
                    node      <= '0;
                    latch_cnt <= '0;
                end
                S_HIGH: begin
                    phase <= phase + 1'b1;
                end
                S_LOW: begin
                    if (bit_done) begin
                        phase   <= '0;
                        act_buf <= act_buf >> 1;
                        if (last_bit) begin
                            latch_cnt <= '0;
                        end else if (cbit == 5'd23) begin
                            cbit <= '0;
                            node <= node + 1'b1;
                        end else begin
                            cbit <= cbit + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (latch_done) begin
                        latch_cnt <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs, decoded from the state being entered so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout       <= (state_next == S_HIGH);
            busy       <= (state_next != S_IDLE);
            frame_done <= (state == S_LATCH) && latch_done;
        end
    end

endmodule
